// File: rtl/seq_divider_6by3.sv
// seq_divider_6by3: multi-cycle restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor with a
// start/ready/done handshake. Results and the divide-by-zero flag are
// registered and held until the next completion or reset.
module seq_divider_6by3 #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q,       state_d;
    logic [DW-1:0]     dividend_sh_q, dividend_sh_d;
    logic [WIDTH-1:0]  divisor_q,     divisor_d;
    logic [WIDTH-1:0]  pr_q,          pr_d;
    logic [DW-1:0]     quo_sh_q,      quo_sh_d;
    logic [CW-1:0]     count_q,       count_d;
    logic [DW-1:0]     quotient_q,    quotient_d;
    logic [WIDTH-1:0]  remainder_q,   remainder_d;
    logic              dbz_q,         dbz_d;
    logic              ready_q,       ready_d;
    logic              done_q,        done_d;

    // Iteration datapath
    logic [WIDTH:0]    pr_wide;
    logic [WIDTH:0]    pr_diff;
    logic              q_bit;
    logic [WIDTH-1:0]  pr_next;
    logic [DW-1:0]     quo_next;

    // One restoring step. The partial remainder is stored as WIDTH bits
    // because it is always below the divisor between steps; the extra bit
    // only exists in the shifted value for the compare/subtract. Given that
    // bound, the MSB of the (WIDTH+1)-bit difference is exactly the borrow,
    // so pr_wide >= divisor is ~pr_diff[WIDTH].
    always_comb begin
        pr_wide  = {pr_q, dividend_sh_q[DW-1]};
        pr_diff  = pr_wide - {1'b0, divisor_q};
        q_bit    = ~pr_diff[WIDTH];
        pr_next  = q_bit ? pr_diff[WIDTH-1:0] : pr_wide[WIDTH-1:0];
        quo_next = {quo_sh_q[DW-2:0], q_bit};
    end

    // Next-state and next-output computation for the IDLE/CALC/DONE sequence
    always_comb begin
        state_d       = state_q;
        dividend_sh_d = dividend_sh_q;
        divisor_d     = divisor_q;
        pr_d          = pr_q;
        quo_sh_d      = quo_sh_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        dbz_d         = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dividend_sh_d = dividend;
                        divisor_d     = divisor;
                        pr_d          = '0;
                        quo_sh_d      = '0;
                        count_d       = CW'(DW);
                        state_d       = S_CALC;
                    end else begin
                        quotient_d    = '1;
                        remainder_d   = '0;
                        dbz_d         = 1'b1;
                        state_d       = S_DONE;
                    end
                end
            end
            S_CALC: begin
                pr_d          = pr_next;
                dividend_sh_d = {dividend_sh_q[DW-2:0], 1'b0};
                quo_sh_d      = quo_next;
                count_d       = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    quotient_d  = quo_next;
                    remainder_d = pr_next;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            dividend_sh_q <= '0;
            divisor_q     <= '0;
            pr_q          <= '0;
            quo_sh_q      <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            dbz_q         <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dividend_sh_q <= dividend_sh_d;
            divisor_q     <= divisor_d;
            pr_q          <= pr_d;
            quo_sh_q      <= quo_sh_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            dbz_q         <= dbz_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider_6by3.md
Name: seq_divider_6by3

Overview:
- Multi-cycle restoring divider; the inverse operation of the team's 3-bit array multiplier.
- Divides a 2*WIDTH-bit dividend (product width) by a WIDTH-bit divisor. Produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Produces one quotient bit per clock. Uses a start/ready/done handshake.
- Used to check and invert multiplier results in the arithmetic datapath.

Parameters:
- WIDTH, 3, divisor and remainder width.
- Dividend and quotient width is DW = 2*WIDTH (6 by default).

Ports:
- clk  input  1  rising-edge clock; the single clock.
- reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
- start  input  1  request; sampled only when ready=1.
- dividend  input  DW  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- ready  output  1  1 in IDLE only.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  DW  registered result.
- remainder  output  WIDTH  registered result.
- div_by_zero  output  1  registered flag; valid with done and held with the results.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, ready=1, done=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - Internal shift, partial-remainder and counter registers cleared.
  - Reset wins over start and aborts any operation in flight. No done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - If start=1 at the edge and divisor!=0: latch operands into internal registers, set partial remainder=0 and count=DW, go to CALC.
  - If start=1 and divisor==0: go to DONE with quotient={DW{1'b1}}, remainder=0, div_by_zero=1.
  - If start=0: stay in IDLE.
- CALC (ready=0), one iteration per edge:
  - pr (WIDTH+1 bits) = {pr[WIDTH-1:0], dividend_sh[DW-1]}.
  - dividend_sh shifts left by 1.
  - If pr >= {1'b0,divisor}: pr = pr - divisor and the new quotient bit = 1; else the quotient bit = 0.
  - Quotient bits shift in at the LSB, MSB first.
  - count decrements. On the edge where count goes 1 to 0, load the outputs: quotient, remainder = pr[WIDTH-1:0], div_by_zero=0. Go to DONE.
- DONE:
  - done=1 for exactly one cycle, ready=0. Next state is IDLE unconditionally.
  - start during DONE is ignored; the requester must wait for ready=1.
- Latency: start accepted at edge E0. For a nonzero divisor, done is high in the cycle after edge E0+DW (DW+1 cycles after acceptance; 7 at default). For a zero divisor, done is high in the cycle after E0. Throughput is one operation per DW+2 cycles.
- start while ready=0 is ignored. Operand changes while busy have no effect because operands are latched at acceptance.
- quotient, remainder and div_by_zero hold their last values from the DONE transition until the next completion or reset. They do not change during CALC.
- Invariant for a nonzero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.
- The remainder always fits in WIDTH bits because pr < divisor after each iteration. The pr MSB exists only for the compare/subtract.
- The quotient is unsigned. Dividend < divisor gives quotient=0, remainder=dividend.

Test Plan:
- Reset, then dividend=42, divisor=5, start pulse → ready drops, done high exactly 7 cycles after the accepting edge, quotient=8, remainder=2, div_by_zero=0, ready=1 the following cycle.
- Corner set, each run in sequence with the results checked: 63/7 → q=9 r=0; 63/1 → q=63 r=0; 5/7 → q=0 r=5; 0/3 → q=0 r=0; 36/6 → q=6 r=0 (round-trips the 6*6 multiplier product).
- dividend=20, divisor=0, start → done in the cycle after acceptance, quotient=63, remainder=0, div_by_zero=1. A following 20/3 → q=6 r=2 with div_by_zero=0.
- Start 42/5; hold start=1 and change the operands to 9/2 during CALC and during DONE → result still q=8 r=2. The next operation is accepted only when ready=1.
- Start 63/7; assert reset for one cycle at cycle 3 of CALC → no done pulse, all outputs 0, ready=1. A new start of 10/3 then gives q=3 r=1 at the normal latency.
- Exhaustive sweep: all 64 dividends × 7 nonzero divisors, back-to-back starts issued as soon as ready=1 → every result satisfies q*d+r==dividend and r<d, with exactly one done per accepted start.
